// File: rtl/rainbow_pkg.sv
// -----------------------------------------------------------------------------
// rainbow_pkg
// Shared types and constants for the rainbow pixel generator:
//   rgb_t        packed {r,g,b}, 8 bits per channel
//   HUE_PERIOD   number of hue steps in one full colour wheel
//   HUE_SECTOR   hue steps per colour sector (three sectors per wheel)
//   gen_state_t  frame FSM states
//   hue_advance  hue accumulator update with wrap at HUE_PERIOD
// -----------------------------------------------------------------------------
package rainbow_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int HUE_PERIOD = 192;
    localparam int HUE_SECTOR = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } gen_state_t;

    // Step is rng nibble + 1 (1..16). The 9-bit sum peaks at 191 + 16 = 207,
    // so a single conditional subtract is enough to wrap back into 0..191.
    function automatic logic [7:0] hue_advance(input logic [7:0] hue,
                                               input logic [3:0] step_m1);
        logic [8:0] sum;
        sum = {1'b0, hue} + {5'b0, step_m1} + 9'd1;
        if (sum >= 9'(HUE_PERIOD)) begin
            sum = sum - 9'(HUE_PERIOD);
        end
        return sum[7:0];
    endfunction

endpackage

// File: rtl/rainbow_pixel_gen_if.sv
// -----------------------------------------------------------------------------
// rainbow_pixel_gen_if
// Pixel stream between the generator (master) and the image writer (slave).
//   pix_valid  master -> slave  pixel available
//   pix_ready  slave  -> master pixel accepted this cycle
//   pix_rgb    master -> slave  {R,G,B}
//   pix_x      master -> slave  column of the current pixel
//   pix_y      master -> slave  row of the current pixel
//   pix_last   master -> slave  current pixel is the final one of the frame
// -----------------------------------------------------------------------------
interface rainbow_pixel_gen_if #(
    parameter int XW = 6,
    parameter int YW = 6
);
    logic          pix_valid;
    logic          pix_ready;
    logic [23:0]   pix_rgb;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          pix_last;

    modport master (
        output pix_valid, pix_rgb, pix_x, pix_y, pix_last,
        input  pix_ready
    );

    modport slave (
        input  pix_valid, pix_rgb, pix_x, pix_y, pix_last,
        output pix_ready
    );
endinterface

// File: rtl/rainbow_hue2rgb.sv
// -----------------------------------------------------------------------------
// rainbow_hue2rgb
// Purely combinational hue (0..191) to RGB mapping: three 64-step sectors,
// each a linear cross-fade between two primaries.
//   hue  in   8-bit hue
//   rgb  out  rgb_t colour
// -----------------------------------------------------------------------------
module rainbow_hue2rgb
    import rainbow_pkg::*;
(
    input  logic [7:0] hue,
    output rgb_t       rgb
);

    logic [7:0] f;

    // Position inside the sector, scaled to 0..252.
    assign f = {hue[5:0], 2'b00};

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave a bit unassigned and infer a latch.
        rgb = '0;
        case (hue[7:6])
            2'd0: begin
                rgb.r = 8'd255 - f;
                rgb.g = f;
            end
            2'd1: begin
                rgb.g = 8'd255 - f;
                rgb.b = f;
            end
            2'd2: begin
                rgb.r = f;
                rgb.b = 8'd255 - f;
            end
            default: rgb = '0;
        endcase
    end

endmodule

// File: rtl/rainbow_pixel_gen.sv
// -----------------------------------------------------------------------------
// rainbow_pixel_gen
// Walks an IMG_W x IMG_H frame in raster order after a start pulse and emits
// one randomised-rainbow pixel per valid/ready handshake.
//   clk    in   system clock, rising edge
//   reset  in   asynchronous, active-low reset
//   rng    in   16-bit LFSR word; [3:0] hue step, [15:10] dither
//   start  in   one-cycle frame request (honoured only in IDLE)
//   busy   out  frame in progress
//   done   out  one-cycle pulse after the last pixel is accepted
//   pix    master side of rainbow_pixel_gen_if
// Build option: define RAINBOW_DITHER_EN to XOR registered rng[15:10] into
// the two LSBs of each colour channel.
// -----------------------------------------------------------------------------
module rainbow_pixel_gen
    import rainbow_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int XW    = $clog2(IMG_W),
    parameter int YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [15:0]         rng,
    input  logic                start,
    output logic                busy,
    output logic                done,
    rainbow_pixel_gen_if.master pix
);

    localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

    gen_state_t    state_q, state_d;
    logic [7:0]    hue_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic          last;
    logic          hs;
    logic          launch;
    rgb_t          hue_rgb;
    rgb_t          out_rgb;

    // rng[9:4] never carries information here; [15:10] only with dither.
    logic unused_rng;
    assign unused_rng = ^rng[15:4];

    assign last   = (x_q == X_MAX) && (y_q == Y_MAX);
    assign hs     = (state_q == RUN) && pix.pix_ready;
    assign launch = (state_q == IDLE) && start;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of block ordering.
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)     state_d = RUN;
            RUN:     if (hs && last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- counters and hue accumulator ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hue_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
        end else if (launch) begin
            hue_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
        end else if (hs) begin
            hue_q <= hue_advance(hue_q, rng[3:0]);
            if (x_q == X_MAX) begin
                x_q <= '0;
                // Wrapping y on the final pixel leaves the counters at the
                // origin, so pix_last reads 0 outside a frame.
                y_q <= (y_q == Y_MAX) ? '0 : y_q + 1'b1;
            end else begin
                x_q <= x_q + 1'b1;
            end
        end
    end

    rainbow_hue2rgb u_hue2rgb (
        .hue (hue_q),
        .rgb (hue_rgb)
    );

`ifdef RAINBOW_DITHER_EN
    logic [5:0] dither_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dither_q <= '0;
        end else if (launch || hs) begin
            dither_q <= rng[15:10];
        end
    end

    always_comb begin
        out_rgb        = hue_rgb;
        out_rgb.r[1:0] = hue_rgb.r[1:0] ^ dither_q[1:0];
        out_rgb.g[1:0] = hue_rgb.g[1:0] ^ dither_q[3:2];
        out_rgb.b[1:0] = hue_rgb.b[1:0] ^ dither_q[5:4];
    end
`else
    assign out_rgb = hue_rgb;
`endif

    // ---------------- outputs ----------------
    assign busy          = (state_q == RUN);
    assign done          = (state_q == DONE);
    assign pix.pix_valid = busy;
    // Colour is forced to zero outside RUN so idle/done outputs are all-zero.
    assign pix.pix_rgb   = busy ? out_rgb : 24'h0;
    assign pix.pix_x     = x_q;
    assign pix.pix_y     = y_q;
    assign pix.pix_last  = last;

endmodule

// File: doc/rainbow_pixel_gen.md
Name: rainbow_pixel_gen

Overview:
- Downstream consumer of the 16-bit rainbow LFSR word.
- On a start pulse, walks one IMG_W x IMG_H frame in raster order and emits one 24-bit RGB pixel per valid/ready handshake.
- Pixel colour comes from a hue accumulator that advances by an LFSR-derived random step, giving a randomised rainbow sweep.
- Feeds the image writer / framebuffer stage.

Parameters:
- IMG_W, 64, pixels per row (>=2).
- IMG_H, 64, rows per frame (>=1).
- XW, $clog2(IMG_W), width of pix_x.
- YW, $clog2(IMG_H), width of pix_y.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rng  in  16  LFSR word, new value every cycle.
- start  in  1  one-cycle frame request.
- busy  out  1  high while a frame is in progress (RUN).
- done  out  1  one-cycle pulse after the last pixel is accepted.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  downstream accepts the pixel.
- pix_rgb  out  24  {R,G,B}, 8 bits each.
- pix_x  out  XW  column of the current pixel.
- pix_y  out  YW  row of the current pixel.
- pix_last  out  1  current pixel is (IMG_W-1, IMG_H-1).

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset is asynchronous and active-low.
  - On reset: state IDLE; hue=0, x=0, y=0, dither reg=0; busy=0, done=0, pix_valid=0, pix_rgb=0, pix_x=0, pix_y=0, pix_last=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 moves to RUN next cycle, with hue=0, x=0, y=0, dither reg<=rng[15:10]. Latency is 1: pix_valid is high in the cycle after start.
- RUN:
  - pix_valid=1 and busy=1.
  - Handshake = pix_valid & pix_ready.
  - On each handshake: hue<=wrap(hue + rng[3:0] + 1); dither reg<=rng[15:10]; x increments.
  - When x==IMG_W-1: x<=0 and y increments.
  - A handshake with pix_last=1 moves to DONE.
- DONE: done=1, pix_valid=0, busy=0 for exactly one cycle, then IDLE.
- start is ignored in RUN and DONE (no restart, no queueing).
- Stability: pix_rgb, pix_x, pix_y and pix_last change only after a handshake. They must be held constant while pix_valid=1 and pix_ready=0. rng is sampled only at handshake or start.
- Hue arithmetic:
  - 8-bit hue, range 0..191.
  - wrap(h) = h-192 if h>=192, else h. The 9-bit intermediate sum has a maximum of 191+16=207.
  - Step range is 1..16.
- Hue-to-RGB, combinational from registered hue:
  - sector s = hue/64 (0, 1 or 2).
  - f = (hue mod 64)<<2, range 0..252.
  - s0: R=255-f, G=f, B=0.
  - s1: R=0, G=255-f, B=f.
  - s2: R=f, G=0, B=255-f.
- pix_last = (x==IMG_W-1) && (y==IMG_H-1), combinational from counters.
- Reset mid-frame: immediate return to IDLE; all outputs go to reset values; no done pulse.
- IMG_H=1: y stays 0 and pix_last depends only on x.

Optional Feature:
- Macro: RAINBOW_DITHER_EN.
- Defined: pix_rgb is the hue colour XOR dither. R[1:0]^=d[1:0], G[1:0]^=d[3:2], B[1:0]^=d[5:4], using the registered dither bits (so the output stays stable under backpressure).
- Undefined: no dither register; pix_rgb is the pure hue colour; rng[15:10] is unused.

Decomposition:
- Package rainbow_pkg:
  - rgb_t: packed struct {r,g,b} of 8 bits each.
  - HUE_PERIOD=192, HUE_SECTOR=64.
  - gen_state_t enum {IDLE, RUN, DONE}.
- Sub-module rainbow_hue2rgb: purely combinational hue (8-bit) to rgb_t mapping.
- Top module holds the FSM, counters, hue accumulator and dither register.

Test Plan (IMG_W=4, IMG_H=2 unless stated):
- Reset/idle: assert reset mid-stream -> all outputs 0; start ignored while reset is low; no pix_valid.
- Basic frame, rng held at 16'h0000, pix_ready=1:
  - start at cycle 0 -> pix_valid at cycle 1.
  - 8 pixels with hues 0..7; first rgb 24'hFF0000, second 24'hFB0400.
  - pix_last only on (3,1).
  - done pulse one cycle after the 8th handshake; busy low in the DONE cycle.
- Backpressure: hold pix_ready=0 for 3 cycles while rng toggles -> pix_rgb, pix_x, pix_y stay constant; count advances only on handshakes; still exactly 8 pixels.
- Hue wrap, rng=16'h000F (step 16), IMG_W=16, IMG_H=1:
  - pixel 11 has hue 176 -> rgb 24'hC0003F.
  - pixel 12 has hue 0 -> 24'hFF0000.
- Control edges:
  - start pulsed during RUN and during DONE -> ignored.
  - reset asserted after 3 handshakes -> IDLE with no done.
  - a new start then restarts at (0,0) with hue 0.
- With RAINBOW_DITHER_EN, rng=16'hFC00 -> d=6'h3F; first pixel 24'hFC0303.
